// File: rtl/enclave_pkg.sv
// Shared enclave datapath definitions: default LWE parameters, FSM state type
// and the decode shift helper used by the decryption path.
package enclave_pkg;

  localparam int PLAINTEXT_MODULUS  = 64;
  localparam int PLAINTEXT_WIDTH    = 6;
  localparam int CIPHERTEXT_MODULUS = 1024;
  localparam int CIPHERTEXT_WIDTH   = 10;
  localparam int DIMENSION          = 10;

  typedef enum logic {
    ACCUM = 1'b0,
    OUT   = 1'b1
  } dec_state_e;

  function automatic int decode_shift(input int cw, input int pw);
    return cw - pw;
  endfunction

endpackage

// File: rtl/decrypt_if.sv
// Ciphertext-in / plaintext-out stream bundle for the decryption unit.
interface decrypt_if
  import enclave_pkg::*;
#(
  parameter int CW = CIPHERTEXT_WIDTH,
  parameter int PW = PLAINTEXT_WIDTH
) ();

  logic          ct_valid;
  logic          ct_ready;
  logic [CW-1:0] ct_elem;
  logic [CW-1:0] sk_elem;
  logic          pt_valid;
  logic          pt_ready;
  logic [PW-1:0] plaintext;

  // master drives ciphertext and consumes plaintext; slave is the decrypt unit
  modport master (
    output ct_valid, ct_elem, sk_elem, pt_ready,
    input  ct_ready, pt_valid, plaintext
  );

  modport slave (
    input  ct_valid, ct_elem, sk_elem, pt_ready,
    output ct_ready, pt_valid, plaintext
  );

endinterface

// File: rtl/decrypt_mac.sv
// Combinational modular multiply-accumulate: sum = (acc + a*b) mod 2^CW.
module decrypt_mac
  import enclave_pkg::*;
#(
  parameter int CW = CIPHERTEXT_WIDTH
) (
  input  logic [CW-1:0] acc,
  input  logic [CW-1:0] a,
  input  logic [CW-1:0] b,
  output logic [CW-1:0] sum
);

  logic [2*CW-1:0] prod;

  // only the low CW bits of the product survive the mod 2^CW reduction
  assign prod = a * b;
  assign sum  = acc + prod[CW-1:0];

endmodule

// File: rtl/decrypt.sv
// Streaming LWE decryption: accumulates <ct, sk> mod q and decodes the top bits.
// Define DECRYPT_ROUND_EN for round-to-nearest decode; default is truncation.
module decrypt
  import enclave_pkg::*;
#(
  parameter int PLAINTEXT_MODULUS  = enclave_pkg::PLAINTEXT_MODULUS,
  parameter int PLAINTEXT_WIDTH    = $clog2(PLAINTEXT_MODULUS),
  parameter int CIPHERTEXT_MODULUS = enclave_pkg::CIPHERTEXT_MODULUS,
  parameter int CIPHERTEXT_WIDTH   = $clog2(CIPHERTEXT_MODULUS),
  parameter int DIMENSION          = enclave_pkg::DIMENSION
) (
  input  logic      clk,
  input  logic      rst_n,
  decrypt_if.slave  bus
);

  localparam int CW    = CIPHERTEXT_WIDTH;
  localparam int PW    = PLAINTEXT_WIDTH;
  localparam int S     = decode_shift(CW, PW);
  localparam int IDX_W = $clog2(DIMENSION + 1);

  localparam logic [IDX_W-1:0] LAST_IDX   = IDX_W'(DIMENSION);
  localparam logic [CW-1:0]    ROUND_BIAS = CW'(1) << (S - 1);

  dec_state_e       state_q, state_d;
  logic [IDX_W-1:0] idx_q, idx_d;
  logic [CW-1:0]    acc_q, acc_d;
  logic [PW-1:0]    pt_q, pt_d;
  logic [CW-1:0]    mac_sum;
  logic [CW-1:0]    dec_val;

  decrypt_mac #(.CW(CW)) u_mac (
    .acc (acc_q),
    .a   (bus.ct_elem),
    .b   (bus.sk_elem),
    .sum (mac_sum)
  );

`ifdef DECRYPT_ROUND_EN
  // adding half an output step wraps values just below q back to zero
  assign dec_val = mac_sum + ROUND_BIAS;
`else
  assign dec_val = mac_sum;
`endif

  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    acc_d   = acc_q;
    pt_d    = pt_q;
    unique case (state_q)
      ACCUM: begin
        if (bus.ct_valid) begin
          acc_d = mac_sum;
          idx_d = idx_q + IDX_W'(1);
          if (idx_q == LAST_IDX) begin
            pt_d    = dec_val[CW-1:S];
            idx_d   = '0;
            acc_d   = '0;
            state_d = OUT;
          end
        end
      end
      OUT: begin
        if (bus.pt_ready) state_d = ACCUM;
      end
      default: state_d = ACCUM;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ACCUM;
      idx_q   <= '0;
      acc_q   <= '0;
      pt_q    <= '0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      acc_q   <= acc_d;
      pt_q    <= pt_d;
    end
  end

  assign bus.ct_ready  = (state_q == ACCUM);
  assign bus.pt_valid  = (state_q == OUT);
  assign bus.plaintext = pt_q;

endmodule

// File: tb/tb_decrypt.sv
// Scoreboard bench for decrypt: directed vectors with hand-computed plaintexts.
module tb_decrypt;

  localparam int CW = 10;
  localparam int PW = 6;
  localparam int N  = 10;

  logic clk;
  logic rst_n;

  decrypt_if #(.CW(CW), .PW(PW)) bus ();

  decrypt dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  int checks   = 0;
  int failures = 0;

  logic [PW-1:0] exp_q[$];
  string         name_q[$];

  logic [CW-1:0] ct_v[0:N];
  logic [CW-1:0] sk_v[0:N];

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic checkOutput(input string name, input int actual, input int expected);
    checks++;
    if (actual !== expected) begin
      failures++;
      $display("[TB] FAIL %s: got %0d, expected %0d", name, actual, expected);
    end
  endtask

  task automatic clearVector();
    for (int i = 0; i <= N; i++) begin
      ct_v[i] = '0;
      sk_v[i] = CW'((i * 37 + 5) % 1024);
    end
    sk_v[0] = CW'(1);
  endtask

  task automatic expectPlaintext(input string name, input int value);
    exp_q.push_back(PW'(value));
    name_q.push_back(name);
  endtask

  // Drives one full vector; gaps inserts 0..2 idle cycles before each element.
  task automatic applyStimulus(input bit gaps, input string name);
    int budget;
    for (int i = 0; i <= N; i++) begin
      if (gaps) begin
        int idle;
        idle = $urandom_range(0, 2);
        bus.ct_valid = 1'b0;
        for (int g = 0; g < idle; g++) begin
          @(posedge clk); #1;
        end
      end
      bus.ct_valid = 1'b1;
      bus.ct_elem  = ct_v[i];
      bus.sk_elem  = sk_v[i];
      budget = 0;
      while (!bus.ct_ready && budget < 50) begin
        @(posedge clk); #1;
        budget++;
      end
      if (!bus.ct_ready) checkOutput({name, " ct_ready timeout"}, 0, 1);
      @(posedge clk); #1;
    end
    bus.ct_valid = 1'b0;
    bus.ct_elem  = '0;
    bus.sk_elem  = '0;
    checkOutput({name, " pt_valid after last"}, int'(bus.pt_valid), 1);
    checkOutput({name, " ct_ready in OUT"}, int'(bus.ct_ready), 0);
  endtask

  task automatic waitDrain(input string name);
    int budget;
    budget = 0;
    while (exp_q.size() != 0 && budget < 100) begin
      @(posedge clk); #1;
      budget++;
    end
    checkOutput({name, " drain"}, exp_q.size(), 0);
  endtask

  task automatic checkResetState(input string name);
    checkOutput({name, " ct_ready"}, int'(bus.ct_ready), 1);
    checkOutput({name, " pt_valid"}, int'(bus.pt_valid), 0);
    checkOutput({name, " plaintext"}, int'(bus.plaintext), 0);
  endtask

  // Monitor: every plaintext handshake pops one expected value.
  always @(negedge clk) begin
    if (rst_n && bus.pt_valid && bus.pt_ready) begin
      if (exp_q.size() == 0) begin
        checkOutput("unexpected plaintext", int'(bus.plaintext), -1);
      end else begin
        checkOutput({"plaintext ", name_q.pop_front()}, int'(bus.plaintext),
                    int'(exp_q.pop_front()));
      end
    end
  end

  initial begin
    #500000;
    $display("[TB] FAIL watchdog: got timeout, expected completion");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    logic [PW-1:0] held;
    rst_n        = 1'b0;
    bus.ct_valid = 1'b0;
    bus.ct_elem  = '0;
    bus.sk_elem  = '0;
    bus.pt_ready = 1'b1;
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b1;
    @(posedge clk); #1;
    checkResetState("reset");

    // rounding: 344 -> 22 rounded, 21 truncated
    clearVector();
    ct_v[0] = 10'd344;
`ifdef DECRYPT_ROUND_EN
    expectPlaintext("rounding", 22);
`else
    expectPlaintext("rounding", 21);
`endif
    applyStimulus(1'b0, "rounding");
    waitDrain("rounding");

    // wrap: 1020 -> 0 rounded, 63 truncated
    clearVector();
    ct_v[0] = 10'd1020;
`ifdef DECRYPT_ROUND_EN
    expectPlaintext("wrap", 0);
`else
    expectPlaintext("wrap", 63);
`endif
    applyStimulus(1'b0, "wrap");
    waitDrain("wrap");

    // back-to-back: 512*3 mod 1024 = 512 -> 32, then 5*7+100*2 = 235
    clearVector();
    ct_v[1] = 10'd512; sk_v[1] = 10'd3;
    expectPlaintext("prod wrap", 32);
    applyStimulus(1'b0, "prod wrap");
    clearVector();
    ct_v[1] = 10'd5;   sk_v[1] = 10'd7;
    ct_v[2] = 10'd100; sk_v[2] = 10'd2;
`ifdef DECRYPT_ROUND_EN
    expectPlaintext("sum235", 15);
`else
    expectPlaintext("sum235", 14);
`endif
    applyStimulus(1'b0, "sum235");
    waitDrain("back-to-back");

    // same 235 vector with random valid gaps
`ifdef DECRYPT_ROUND_EN
    expectPlaintext("gaps", 15);
`else
    expectPlaintext("gaps", 14);
`endif
    applyStimulus(1'b1, "gaps");
    waitDrain("gaps");

    // output backpressure: 344 held for 5 cycles
    clearVector();
    ct_v[0] = 10'd344;
`ifdef DECRYPT_ROUND_EN
    held = 6'd22;
`else
    held = 6'd21;
`endif
    bus.pt_ready = 1'b0;
    expectPlaintext("hold", int'(held));
    applyStimulus(1'b0, "hold");
    for (int c = 0; c < 5; c++) begin
      @(posedge clk); #1;
      checkOutput("hold pt_valid", int'(bus.pt_valid), 1);
      checkOutput("hold ct_ready", int'(bus.ct_ready), 0);
      checkOutput("hold plaintext", int'(bus.plaintext), int'(held));
    end
    bus.pt_ready = 1'b1;
    waitDrain("hold");

    // reset after 4 elements of a non-zero vector
    for (int i = 0; i < 4; i++) begin
      bus.ct_valid = 1'b1;
      bus.ct_elem  = CW'(300 + i);
      bus.sk_elem  = CW'(1);
      @(posedge clk); #1;
    end
    bus.ct_valid = 1'b0;
    rst_n = 1'b0;
    #1;
    checkOutput("async reset plaintext", int'(bus.plaintext), 0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    @(posedge clk); #1;
    checkResetState("mid reset");
    clearVector();
    ct_v[0] = 10'd344;
`ifdef DECRYPT_ROUND_EN
    expectPlaintext("after reset", 22);
`else
    expectPlaintext("after reset", 21);
`endif
    applyStimulus(1'b0, "after reset");
    waitDrain("after reset");

    repeat (3) @(posedge clk);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
